div_unit: RTL

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU operations. It sits beside the ALU in the EX stage and takes operands from the ID/EX register after forwarding. While it runs it drives the division stall to the hazard unit, so the divide instruction holds in EX. It returns a result that is muxed into the EX/MEM `alu_result`.

---
 rtl/div_unit_if.sv | 34 +++
 rtl/div_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// ALU operation encoding shared by the EX stage, plus the handshake
// interface of the iterative divider.
//
// alu_pkg     : XLEN and the alu_op_e enumeration (divide ops included).
// div_unit_if : start/op/a/b/flush from the EX stage (master),
//               busy/done/result back from the divider (slave).
package alu_pkg;
  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
    ALU_LUI, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;
endpackage

interface div_unit_if #(parameter int WIDTH = alu_pkg::XLEN);
  import alu_pkg::*;

  logic             start;
  alu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, a, b, flush,
                  input  busy, done, result);
  modport slave  (input  start, op, a, b, flush,
                  output busy, done, result);
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   dif  - div_unit_if.slave: start/op/a/b/flush in, busy/done/result out
//
// A normal divide takes 32 CALC cycles plus one FIXUP cycle while busy is
// high, then presents result with a one-cycle done pulse. Divide-by-zero and
// signed overflow are resolved at start and answer in the next cycle without
// raising busy. All outputs are registered.
module div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave dif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic             is_rem;

  logic             is_div_op;
  logic             op_signed;
  logic             op_rem;
  logic             accept;
  logic             div_zero;
  logic             sgn_ovf;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // Two's complement negation when requested, truncated to WIDTH.
  function automatic logic [WIDTH-1:0] neg_if(input logic signed [WIDTH-1:0] v,
                                              input logic                    neg);
    return neg ? -v : v;
  endfunction

  // Magnitude of a signed operand; the most negative value maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  always_comb begin
    is_div_op = (dif.op == ALU_DIV) || (dif.op == ALU_DIVU) ||
                (dif.op == ALU_REM) || (dif.op == ALU_REMU);
    op_signed = (dif.op == ALU_DIV) || (dif.op == ALU_REM);
    op_rem    = (dif.op == ALU_REM) || (dif.op == ALU_REMU);
    // Flush beats a same-cycle start; starts while busy are dropped.
    accept    = dif.start && !dif.flush && is_div_op &&
                ((state == IDLE) || (state == DONE));
    div_zero  = (dif.b == '0);
    sgn_ovf   = op_signed && (dif.a == {1'b1, {(WIDTH-1){1'b0}}}) && (dif.b == '1);
  end

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits.
  always_comb begin
    rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    rem_nxt = rem_sh;
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    if (rem_sh >= {1'b0, dvs}) begin
      rem_nxt    = rem_sh - {1'b0, dvs};
      quo_nxt[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      quo        <= '0;
      rem        <= '0;
      dvs        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      is_rem     <= 1'b0;
      dif.busy   <= 1'b0;
      dif.done   <= 1'b0;
      dif.result <= '0;
    end else begin
      dif.done <= 1'b0;
      if (dif.flush) begin
        state    <= IDLE;
        cnt      <= '0;
        dif.busy <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (accept) begin
              is_rem <= op_rem;
              neg_q  <= op_signed && (dif.a[WIDTH-1] ^ dif.b[WIDTH-1]);
              neg_r  <= op_signed && dif.a[WIDTH-1];
              quo    <= op_signed ? abs_val(dif.a) : dif.a;
              dvs    <= op_signed ? abs_val(dif.b) : dif.b;
              rem    <= '0;
              cnt    <= '0;
              if (div_zero) begin
                dif.result <= op_rem ? dif.a : '1;
                dif.done   <= 1'b1;
                state      <= DONE;
              end else if (sgn_ovf) begin
                dif.result <= op_rem ? '0 : dif.a;
                dif.done   <= 1'b1;
                state      <= DONE;
              end else begin
                dif.busy <= 1'b1;
                state    <= CALC;
              end
            end else begin
              state <= IDLE;
            end
          end
          // ---- CALC: one quotient bit per cycle ----
          CALC: begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= FIXUP;
          end
          // ---- FIXUP: restore signs and present the result ----
          FIXUP: begin
            dif.result <= is_rem ? neg_if(rem[WIDTH-1:0], neg_r) : neg_if(quo, neg_q);
            dif.busy   <= 1'b0;
            dif.done   <= 1'b1;
            state      <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
